// File: rtl/i2c_master_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2c_master_datapath                                           |
// | Brief    : I2C master bit datapath: SCL generator, SDA shift/mux, RX     |
// |            sampling, FIFO handshakes, arbitration-loss detection.        |
// |            Optional macro I2C_CLK_STRETCH_EN honours slave clock stretch.|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module i2c_master_datapath #(
  parameter int DIV    = 4,
  parameter int ADDR_W = 7
) (
  input  logic              i2c_core_clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] slave_addr_i,
  input  logic              rw_i,
  input  logic              clk_en_i,
  input  logic              sda_low_en_i,
  input  logic              write_addr_en_i,
  input  logic              write_data_en_i,
  input  logic              receive_data_en_i,
  input  logic [2:0]        count_bit_i,
  input  logic              i2c_sda_en_i,
  input  logic              i2c_scl_en_i,
  input  logic              i2c_sda_i,
  input  logic              i2c_scl_i,
  input  logic [7:0]        tx_data_i,
  output logic              tx_rd_o,
  output logic [7:0]        rx_data_o,
  output logic              rx_wr_o,
  output logic              sda_o,
  output logic              scl_o,
  output logic              arb_lost_o
);

  localparam int                 c_cnt_w   = $clog2(DIV);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DIV - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_scl_q;
  logic               r_scl_prev;
  logic               r_wa_prev;
  logic               r_wd_prev;
  logic [7:0]         r_addr_sr;
  logic [7:0]         r_tx_sr;
  logic [7:0]         r_rx_sr;
  logic [7:0]         r_rx_data;
  logic [2:0]         r_rx_cnt;
  logic               r_sda;
  logic               r_scl;
  logic               r_tx_rd;
  logic               r_rx_wr;
  logic               r_arb_lost;

  logic               w_scl_rise;
  logic               w_wa_rise;
  logic               w_wd_rise;
  logic               w_cnt_freeze;
  logic [7:0]         w_addr_load;
  logic               w_addr_bit;
  logic               w_data_bit;
  logic               w_arb_set;
  logic               w_sda_next;
  logic [7:0]         w_rx_byte;

  assign w_scl_rise  = ~r_scl_prev & i2c_scl_i;
  assign w_wa_rise   = write_addr_en_i & ~r_wa_prev;
  assign w_wd_rise   = write_data_en_i & ~r_wd_prev;
  assign w_addr_load = {slave_addr_i[6:0], rw_i};

`ifdef I2C_CLK_STRETCH_EN
  // Slave still holding SCL low after we released it: hold the high phase.
  assign w_cnt_freeze = r_scl_q & ~i2c_scl_i;
`else
  assign w_cnt_freeze = 1'b0;
`endif

  // Bypass the shift register on the load cycle so the first bit is not stale.
  assign w_addr_bit = w_wa_rise ? w_addr_load[count_bit_i] : r_addr_sr[count_bit_i];
  assign w_data_bit = w_wd_rise ? tx_data_i[count_bit_i]   : r_tx_sr[count_bit_i];

  assign w_arb_set = w_scl_rise & r_sda & ~i2c_sda_i & (write_addr_en_i | write_data_en_i);

  always_comb begin
    w_sda_next = 1'b1;
    if (!i2c_sda_en_i) begin
      w_sda_next = 1'b1;
    end else if (sda_low_en_i) begin
      w_sda_next = 1'b0;
    end else if (write_addr_en_i) begin
      w_sda_next = w_addr_bit;
    end else if (write_data_en_i) begin
      w_sda_next = w_data_bit;
    end
    if (r_arb_lost || w_arb_set) begin
      w_sda_next = 1'b1;
    end
  end

  always_comb begin
    w_rx_byte              = r_rx_sr;
    w_rx_byte[count_bit_i] = i2c_sda_i;
  end

  always_ff @(posedge i2c_core_clk_i) begin
    if (reset_i) begin
      r_cnt      <= '0;
      r_scl_q    <= 1'b1;
      r_scl_prev <= 1'b1;
      r_wa_prev  <= 1'b0;
      r_wd_prev  <= 1'b0;
      r_addr_sr  <= '0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_rx_data  <= '0;
      r_rx_cnt   <= '0;
      r_sda      <= 1'b1;
      r_scl      <= 1'b1;
      r_tx_rd    <= 1'b0;
      r_rx_wr    <= 1'b0;
      r_arb_lost <= 1'b0;
    end else begin
      r_scl_prev <= i2c_scl_i;
      r_wa_prev  <= write_addr_en_i;
      r_wd_prev  <= write_data_en_i;

      if (!clk_en_i) begin
        r_cnt   <= '0;
        r_scl_q <= 1'b1;
      end else if (!w_cnt_freeze) begin
        if (r_cnt == c_cnt_max) begin
          r_cnt   <= '0;
          r_scl_q <= ~r_scl_q;
        end else begin
          r_cnt <= r_cnt + c_cnt_one;
        end
      end
      r_scl <= i2c_scl_en_i ? r_scl_q : 1'b1;

      if (w_wa_rise) begin
        r_addr_sr <= w_addr_load;
      end
      if (w_wd_rise) begin
        r_tx_sr <= tx_data_i;
      end
      r_tx_rd <= w_wd_rise;
      r_sda   <= w_sda_next;

      r_rx_wr <= 1'b0;
      if (!receive_data_en_i) begin
        r_rx_cnt <= '0;
      end else if (w_scl_rise) begin
        r_rx_sr <= w_rx_byte;
        if (r_rx_cnt == 3'd7) begin
          r_rx_cnt  <= '0;
          r_rx_data <= w_rx_byte;
          r_rx_wr   <= 1'b1;
        end else begin
          r_rx_cnt <= r_rx_cnt + 3'd1;
        end
      end

      if (!clk_en_i) begin
        r_arb_lost <= 1'b0;
      end else if (w_arb_set) begin
        r_arb_lost <= 1'b1;
      end
    end
  end

  assign tx_rd_o    = r_tx_rd;
  assign rx_data_o  = r_rx_data;
  assign rx_wr_o    = r_rx_wr;
  assign sda_o      = r_sda;
  assign scl_o      = r_scl;
  assign arb_lost_o = r_arb_lost;

endmodule
`default_nettype wire
